// File: rtl/seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_driver
// Brief    : Scans a 32-bit word as 8 hex digits onto a common-anode display.
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_driver #(
    parameter int SCAN_DIV = 50000,
    parameter int CNT_W    = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] Data_in,
    input  logic [7:0]  dot_in,
    input  logic        blank_lz,
    output logic [7:0]  AN,
    output logic [7:0]  SEGMENT,
    output logic        frame_done
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_idx;
    logic [31:0]      r_snap;
    logic [7:0]       r_an;
    logic [7:0]       r_seg;
    logic             r_frame_done;

    logic             w_tick;
    logic             w_wrap;
    logic [2:0]       w_next_idx;
    logic [31:0]      w_word;
    logic [31:0]      w_upper;
    logic             w_blank;
    logic [7:0]       w_seg;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        case (nib)
            4'h0:    hex_to_seg = 7'h40;
            4'h1:    hex_to_seg = 7'h79;
            4'h2:    hex_to_seg = 7'h24;
            4'h3:    hex_to_seg = 7'h30;
            4'h4:    hex_to_seg = 7'h19;
            4'h5:    hex_to_seg = 7'h12;
            4'h6:    hex_to_seg = 7'h02;
            4'h7:    hex_to_seg = 7'h78;
            4'h8:    hex_to_seg = 7'h00;
            4'h9:    hex_to_seg = 7'h10;
            4'hA:    hex_to_seg = 7'h08;
            4'hB:    hex_to_seg = 7'h03;
            4'hC:    hex_to_seg = 7'h46;
            4'hD:    hex_to_seg = 7'h21;
            4'hE:    hex_to_seg = 7'h06;
            default: hex_to_seg = 7'h0E;
        endcase
    endfunction

    assign w_tick     = (r_cnt == C_CNT_MAX);
    assign w_wrap     = w_tick && (r_idx == 3'd7);
    assign w_next_idx = r_idx + 3'd1;

    // On the wrap edge the snapshot is not yet loaded, so digit 0 reads Data_in directly.
    assign w_word  = (r_idx == 3'd7) ? Data_in : r_snap;
    assign w_upper = w_word >> {w_next_idx, 2'b00};
    assign w_blank = blank_lz && (w_next_idx != 3'd0) && (w_upper == 32'd0);
    assign w_seg   = {~dot_in[w_next_idx], w_blank ? 7'h7F : hex_to_seg(w_upper[3:0])};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_idx        <= 3'd7;
            r_snap       <= 32'd0;
            r_an         <= 8'hFF;
            r_seg        <= 8'hFF;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_wrap;
            if (w_tick) begin
                r_cnt <= '0;
                r_idx <= w_next_idx;
                r_an  <= ~(8'b1 << w_next_idx);
                r_seg <= w_seg;
                if (w_wrap) begin
                    r_snap <= Data_in;
                end
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign AN         = r_an;
    assign SEGMENT    = r_seg;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan_driver
// Brief    : Self-checking bench; two instances (SCAN_DIV=4 and 1) vs a count-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] data_in = 32'd0;
    logic [7:0]  dot_in = 8'd0;
    logic        blank_lz = 1'b0;

    logic [7:0]  an4, seg4, an1, seg1;
    logic        fd4, fd1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    seg_scan_driver #(.SCAN_DIV(4), .CNT_W(16)) dut4 (
        .clk(clk), .rst_n(rst_n), .Data_in(data_in), .dot_in(dot_in),
        .blank_lz(blank_lz), .AN(an4), .SEGMENT(seg4), .frame_done(fd4)
    );

    seg_scan_driver #(.SCAN_DIV(1), .CNT_W(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .Data_in(data_in), .dot_in(dot_in),
        .blank_lz(blank_lz), .AN(an1), .SEGMENT(seg1), .frame_done(fd1)
    );

    // Reference model: per instance, count edges since reset; every div-th edge is a
    // tick, tick k shows digit (k-1) mod 8, and digit 0 starts a new frame.
    int          div_of [2] = '{4, 1};
    int          edges  [2];
    logic [31:0] frame  [2];
    logic [7:0]  m_an   [2];
    logic [7:0]  m_seg  [2];
    logic        m_fd   [2];
    logic [7:0]  hex7   [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] expect_seg(input logic [31:0] w, input int d,
                                              input logic bl, input logic [7:0] dots);
        logic [31:0] upper;
        logic [3:0]  nib;
        logic [7:0]  code;
        upper = w >> (4 * d);
        nib   = upper[3:0];
        code  = hex7[nib];
        if (bl && d > 0 && upper == 32'd0) code = 8'hFF;
        code[7] = ~dots[d];
        return code;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            edges[i] = 0;
            frame[i] = 32'd0;
            m_an[i]  = 8'hFF;
            m_seg[i] = 8'hFF;
            m_fd[i]  = 1'b0;
        end
    endtask

    task automatic model_edge(input logic [31:0] d, input logic [7:0] dots, input logic bl);
        for (int i = 0; i < 2; i++) begin
            m_fd[i] = 1'b0;
            edges[i]++;
            if (edges[i] % div_of[i] == 0) begin
                int dg;
                dg = ((edges[i] / div_of[i]) - 1) % 8;
                if (dg == 0) begin
                    frame[i] = d;
                    m_fd[i]  = 1'b1;
                end
                m_an[i]  = ~(8'b1 << dg);
                m_seg[i] = expect_seg(frame[i], dg, bl, dots);
            end
        end
    endtask

    task automatic check_all();
        chk("an_div4",  an4,  m_an[0]);
        chk("seg_div4", seg4, m_seg[0]);
        chk("fd_div4",  fd4,  m_fd[0]);
        chk("an_div1",  an1,  m_an[1]);
        chk("seg_div1", seg1, m_seg[1]);
        chk("fd_div1",  fd1,  m_fd[1]);
    endtask

    // One clock: capture the inputs seen by the edge, advance the model, compare.
    task automatic step();
        logic [31:0] d;
        logic [7:0]  dt;
        logic        bl;
        logic        r;
        d = data_in; dt = dot_in; bl = blank_lz; r = rst_n;
        @(posedge clk);
        #1;
        if (r) model_edge(d, dt, bl);
        check_all();
    endtask

    task automatic wait_an4(input logic [7:0] target);
        for (int i = 0; i < 40 && an4 !== target; i++) step();
        chk("wait_an4", an4, target);
    endtask

    initial begin
        int pulses4, pulses1;

        // Test 1: reset and first tick
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("reset_an",  an4, 8'hFF);
        chk("reset_seg", seg4, 8'hFF);
        chk("reset_fd",  fd4, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("div1_first_an", an1, 8'hFE);
        step(); step();
        chk("pre_tick_an", an4, 8'hFF);
        step();
        chk("first_tick_an",  an4, 8'hFE);
        chk("first_tick_seg", seg4, 8'hC0);

        // Test 2: full frame, frame_done rate
        data_in = 32'h89AB_CDEF;
        for (int i = 0; i < 32; i++) step();
        pulses4 = 0; pulses1 = 0;
        for (int i = 0; i < 32; i++) begin
            step();
            pulses4 += int'(fd4);
            pulses1 += int'(fd1);
        end
        chk("fd4_per_32", pulses4, 1);
        chk("fd1_per_32", pulses1, 4);

        // Test 3: snapshot isolation
        data_in = 32'h1111_1111;
        for (int i = 0; i < 40; i++) step();
        wait_an4(8'hF7);
        data_in = 32'h2222_2222;
        wait_an4(8'hEF);
        chk("snap_digit4", seg4, 8'hF9);
        wait_an4(8'hFE);
        chk("new_frame_digit0", seg4, 8'hA4);

        // Test 4: leading-zero blanking with dp on a non-blank digit
        data_in = 32'h0000_0105; blank_lz = 1'b1; dot_in = 8'h04;
        for (int i = 0; i < 40; i++) step();
        wait_an4(8'hFB);
        chk("blank_dp_digit2", seg4, 8'h79);
        wait_an4(8'hF7);
        chk("blank_digit3", seg4, 8'hFF);

        // Test 5: async reset mid-scan
        wait_an4(8'hDF);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_rst_an",  an4, 8'hFF);
        chk("async_rst_seg", seg4, 8'hFF);
        chk("async_rst_an1", an1, 8'hFF);
        step(); step();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("post_rst_tick_an", an4, 8'hFE);

        // Randomized: data with random leading zeros, live dot/blank changes
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                int sh;
                sh = $urandom_range(0, 8);
                data_in = (sh == 8) ? 32'd0 : ($urandom() >> (4 * sh));
            end
            dot_in   = 8'($urandom());
            blank_lz = 1'($urandom());
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
